// File: rtl/cga_vram_arbiter_if.sv
// Signal bundle between the CGA VRAM arbiter, the ISA bus decode, the display
// sequencer and the external video RAM pins.
interface cga_vram_arbiter_if;
  logic [19:0] bus_a;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_d;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;
  logic        tandy_32k;
  logic [18:0] vid_a;
  logic        vid_read;
  logic        isa_op_enable;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_d;

  modport slave (
    input  bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d, tandy_32k,
    input  vid_a, vid_read, isa_op_enable, ram_d,
    output bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_wd
  );

  modport master (
    output bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d, tandy_32k,
    output vid_a, vid_read, isa_op_enable, ram_d,
    input  bus_out, bus_dir, bus_rdy, ram_a, ram_we_l, ram_wd
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA video RAM between sequencer video fetches (always win) and
// parked ISA CPU accesses that execute in the sequencer's CPU slots.
module cga_vram_arbiter #(
  parameter logic [4:0] FB_BASE      = 5'h17,
  parameter bit         USE_BUS_WAIT = 1'b1,
  parameter logic [3:0] RAM_HI       = 4'b0001
) (
  input  logic                  clk,
  input  logic                  reset_l,
  cga_vram_arbiter_if.slave     bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACC0,
    ST_ACC1,
    ST_DONE
  } state_e;

  state_e      state_q;
  logic        memr_s1_q, memr_s_q;
  logic        memw_s1_q, memw_s_q;
  logic [14:0] offset_q;
  logic        wr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;

  logic mem_cs;
  logic req;
  logic in_access;

  assign mem_cs    = (bus.bus_a[19:15] == FB_BASE) & ~bus.bus_aen;
  assign req       = mem_cs & (~memr_s_q | ~memw_s_q);
  assign in_access = (state_q == ST_ACC0) || (state_q == ST_ACC1);

  // Control: strobe synchronisers, access sequencing and read capture
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= ST_IDLE;
      memr_s1_q <= 1'b1;
      memr_s_q  <= 1'b1;
      memw_s1_q <= 1'b1;
      memw_s_q  <= 1'b1;
      rdata_q   <= 8'h00;
    end else begin
      memr_s1_q <= bus.bus_memr_l;
      memr_s_q  <= memr_s1_q;
      memw_s1_q <= bus.bus_memw_l;
      memw_s_q  <= memw_s1_q;
      case (state_q)
        ST_IDLE: if (req) state_q <= ST_WAIT;
        ST_WAIT: if (bus.isa_op_enable && !bus.vid_read) state_q <= ST_ACC0;
        ST_ACC0: state_q <= ST_ACC1;
        ST_ACC1: begin
          // A video fetch stealing the second clock voids the slot; retry later
          if (bus.vid_read) begin
            state_q <= ST_WAIT;
          end else begin
            if (!wr_q) rdata_q <= bus.ram_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: if (memr_s_q && memw_s_q) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request latch: address offset, direction and write data held while parked
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req) begin
      offset_q <= {bus.tandy_32k & bus.bus_a[14], bus.bus_a[13:0]};
      wr_q     <= ~memw_s_q;
      wdata_q  <= bus.bus_d;
    end
  end

  assign bus.ram_a    = in_access ? {RAM_HI, offset_q} : bus.vid_a;
  assign bus.ram_wd   = wdata_q;
  // Write strobe depends on this clock's vid_read so an aborted slot never writes
  assign bus.ram_we_l = ~((state_q == ST_ACC1) & wr_q & ~bus.vid_read);

  assign bus.bus_dir  = mem_cs & ~bus.bus_memr_l;
  assign bus.bus_out  = bus.bus_dir ? rdata_q : 8'h00;

  generate
    if (USE_BUS_WAIT) begin : g_bus_wait
      // Raw strobes so the wait reaches the bus in the same clock; forced ready in reset
      assign bus.bus_rdy = ~reset_l |
                           ~(mem_cs & (~bus.bus_memr_l | ~bus.bus_memw_l) &
                             (state_q != ST_DONE));
    end else begin : g_no_wait
      assign bus.bus_rdy = 1'b1;
    end
  endgenerate

endmodule
